io_bus_frontend: RTL and testbench



---
 rtl/io_bus_frontend_pkg.sv | 25 ++
 rtl/io_bus_frontend_if.sv | 28 ++
 rtl/io_bus_frontend_strobe_filter.sv | 51 +++++
 rtl/io_bus_frontend.sv | 76 +++++++
 tb/tb_io_bus_frontend.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_frontend_pkg.sv
// Shared constants and types for the IO-block bus front-end: filter defaults,
// strobe inactive levels and the glitch-filter counter type.
package io_bus_pkg;

  localparam int unsigned DEFAULT_FILTER_LEN = 2;
  localparam int unsigned CNT_W              = 4;

  localparam logic LE_IDLE  = 1'b0;
  localparam logic STB_IDLE = 1'b1;

  typedef logic [CNT_W-1:0] filt_cnt_t;

  typedef struct packed {
    logic le_lo;
    logic le_hi;
    logic web;
    logic oeb;
  } strobes_t;

  // Terminal count: filt flips on the cycle the counter already holds this value.
  function automatic filt_cnt_t filt_last(input int unsigned len);
    return filt_cnt_t'(len - 1);
  endfunction

endpackage

// File: rtl/io_bus_frontend_if.sv
// External bus pins plus the filtered strobes, data byte and latched address
// presented to the IO-block register slaves.
interface io_bus_frontend_if;

  logic        le_lo_pin;
  logic        le_hi_pin;
  logic        web_pin;
  logic        oeb_pin;
  logic [7:0]  bus_pins;

  logic        le_lo_act;
  logic        le_hi_act;
  logic        WEb_raw;
  logic        oe_act;
  logic [7:0]  bus_in;
  logic [15:0] addr;

  modport master (
    output le_lo_pin, le_hi_pin, web_pin, oeb_pin, bus_pins,
    input  le_lo_act, le_hi_act, WEb_raw, oe_act, bus_in, addr
  );

  modport slave (
    input  le_lo_pin, le_hi_pin, web_pin, oeb_pin, bus_pins,
    output le_lo_act, le_hi_act, WEb_raw, oe_act, bus_in, addr
  );

endinterface

// File: rtl/io_bus_frontend_strobe_filter.sv
// One asynchronous strobe: 2-FF synchronizer, persistence-count glitch filter
// and registered one-cycle pulses on filtered falling and rising edges.
module strobe_filter
  import io_bus_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN,
  parameter logic        IDLE       = LE_IDLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic filt,
  output logic fall,
  output logic rise
);

  localparam filt_cnt_t LAST = filt_last(FILTER_LEN);

  logic      s1;
  logic      s2;
  logic      filt_d;
  filt_cnt_t cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= IDLE;
      s2     <= IDLE;
      cnt    <= '0;
      filt   <= IDLE;
      filt_d <= IDLE;
      fall   <= 1'b0;
      rise   <= 1'b0;
    end else begin
      s1     <= pin;
      s2     <= s1;
      filt_d <= filt;
      // Pulses compare the level one cycle old against the current one.
      fall   <= filt_d & ~filt;
      rise   <= ~filt_d & filt;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_frontend.sv
// IO-block bus front-end: filters the four external strobes, synchronizes the
// data bus, holds the last valid byte and latches the 16-bit address.
module io_bus_frontend
  import io_bus_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  io_bus_frontend_if.slave  bus
);

  strobes_t   filt;
  strobes_t   fall;
  strobes_t   rise;
  logic [7:0] d1;
  logic [7:0] d2;
  logic [7:0] hold;
  logic [7:0] addr_lo;
  logic [7:0] addr_hi;
  logic       unused_pulses;

  strobe_filter #(.FILTER_LEN(FILTER_LEN), .IDLE(LE_IDLE)) u_le_lo (
    .clk(wb_clk_i), .rst_n(rst_n), .pin(bus.le_lo_pin),
    .filt(filt.le_lo), .fall(fall.le_lo), .rise(rise.le_lo)
  );

  strobe_filter #(.FILTER_LEN(FILTER_LEN), .IDLE(LE_IDLE)) u_le_hi (
    .clk(wb_clk_i), .rst_n(rst_n), .pin(bus.le_hi_pin),
    .filt(filt.le_hi), .fall(fall.le_hi), .rise(rise.le_hi)
  );

  strobe_filter #(.FILTER_LEN(FILTER_LEN), .IDLE(STB_IDLE)) u_web (
    .clk(wb_clk_i), .rst_n(rst_n), .pin(bus.web_pin),
    .filt(filt.web), .fall(fall.web), .rise(rise.web)
  );

  strobe_filter #(.FILTER_LEN(FILTER_LEN), .IDLE(STB_IDLE)) u_oeb (
    .clk(wb_clk_i), .rst_n(rst_n), .pin(bus.oeb_pin),
    .filt(filt.oeb), .fall(fall.oeb), .rise(rise.oeb)
  );

  // Hold tracks the bus while any latch/write strobe is active, so the byte
  // seen on the last active cycle is what the address latch picks up.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      d1      <= '0;
      d2      <= '0;
      hold    <= '0;
      addr_lo <= '0;
      addr_hi <= '0;
    end else begin
      d1 <= bus.bus_pins;
      d2 <= d1;
      if (filt.le_lo | filt.le_hi | ~filt.web) begin
        hold <= d2;
      end
      if (fall.le_lo) begin
        addr_lo <= hold;
      end
      if (fall.le_hi) begin
        addr_hi <= hold;
      end
    end
  end

  assign bus.le_lo_act = fall.le_lo;
  assign bus.le_hi_act = fall.le_hi;
  assign bus.WEb_raw   = filt.web;
  assign bus.oe_act    = ~filt.oeb;
  assign bus.bus_in    = hold;
  assign bus.addr      = {addr_hi, addr_lo};

  assign unused_pulses = ^{fall.web, fall.oeb, rise};

endmodule

// File: tb/tb_io_bus_frontend.sv
// Bench for io_bus_frontend: table of bus transactions on a FILTER_LEN=2 unit
// with a pulse scoreboard, plus reset and FILTER_LEN 1/15 sequences.
module tb_io_bus_frontend;

  localparam int unsigned FL2 = 2;

  typedef struct {
    string       name;
    logic        lo;
    logic        hi;
    logic        web;
    logic        oeb;
    int unsigned width;
    int unsigned hold;
    logic [7:0]  data;
    logic [7:0]  exp_bus;
    logic [15:0] exp_addr;
    logic        exp_lo;
    logic        exp_hi;
    int unsigned exp_web_low;
    int unsigned exp_oe_high;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic        lo;
    logic        hi;
  } pulse_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  pulse_t      sb[$];
  vec_t        vecs[7];

  io_bus_frontend_if a2();
  io_bus_frontend_if a1();
  io_bus_frontend_if a15();

  io_bus_frontend #(.FILTER_LEN(FL2)) dut2 (.wb_clk_i(clk), .rst_n(rst_n), .bus(a2));
  io_bus_frontend #(.FILTER_LEN(1))   dut1 (.wb_clk_i(clk), .rst_n(rst_n), .bus(a1));
  io_bus_frontend #(.FILTER_LEN(15))  dut15 (.wb_clk_i(clk), .rst_n(rst_n), .bus(a15));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic lo, input logic hi,
                              input logic web, input logic oeb,
                              input int unsigned width, input int unsigned hold,
                              input logic [7:0] data, input logic [7:0] exp_bus,
                              input logic [15:0] exp_addr, input logic exp_lo,
                              input logic exp_hi, input int unsigned exp_web_low,
                              input int unsigned exp_oe_high);
    vec_t v;
    v.name = name; v.lo = lo; v.hi = hi; v.web = web; v.oeb = oeb;
    v.width = width; v.hold = hold; v.data = data; v.exp_bus = exp_bus;
    v.exp_addr = exp_addr; v.exp_lo = exp_lo; v.exp_hi = exp_hi;
    v.exp_web_low = exp_web_low; v.exp_oe_high = exp_oe_high;
    return v;
  endfunction

  // Every act pulse on the FILTER_LEN=2 unit must match the oldest expectation.
  always @(negedge clk) begin
    pulse_t p;
    if (a2.le_lo_act === 1'b1 || a2.le_hi_act === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", {30'd0, a2.le_lo_act, a2.le_hi_act}, 32'd0);
      end else begin
        p = sb.pop_front();
        check("pulse_cycle", cyc, p.cyc);
        check("pulse_lo", {31'd0, a2.le_lo_act}, {31'd0, p.lo});
        check("pulse_hi", {31'd0, a2.le_hi_act}, {31'd0, p.hi});
      end
    end
  end

  initial begin
    int unsigned web_low, oe_high, web_first, oe_first, total_e, first;
    int unsigned l1, f1, l15, f15;

    rst_n = 1'b0;
    a2.le_lo_pin = 1'b0;  a2.le_hi_pin = 1'b0;  a2.web_pin = 1'b1;  a2.oeb_pin = 1'b1;  a2.bus_pins = 8'h00;
    a1.le_lo_pin = 1'b0;  a1.le_hi_pin = 1'b0;  a1.web_pin = 1'b1;  a1.oeb_pin = 1'b1;  a1.bus_pins = 8'h00;
    a15.le_lo_pin = 1'b0; a15.le_hi_pin = 1'b0; a15.web_pin = 1'b1; a15.oeb_pin = 1'b1; a15.bus_pins = 8'h00;

    vecs[0] = mk("addr_lo",    1, 0, 0, 0, 6, 4, 8'h34, 8'h34, 16'h0034, 1, 0, 0, 0);
    vecs[1] = mk("addr_hi",    0, 1, 0, 0, 6, 4, 8'h12, 8'h12, 16'h1234, 0, 1, 0, 0);
    vecs[2] = mk("glitch_lo",  1, 0, 0, 0, 1, 0, 8'h55, 8'h12, 16'h1234, 0, 0, 0, 0);
    vecs[3] = mk("glitch_web", 0, 0, 1, 0, 1, 0, 8'h66, 8'h12, 16'h1234, 0, 0, 0, 0);
    vecs[4] = mk("write",      0, 0, 1, 0, 8, 4, 8'hA5, 8'hA5, 16'h1234, 0, 0, 8, 0);
    vecs[5] = mk("oe_read",    0, 0, 0, 1, 5, 0, 8'hC3, 8'hA5, 16'h1234, 0, 0, 0, 5);
    vecs[6] = mk("both_le",    1, 1, 0, 0, 6, 4, 8'h7E, 8'h7E, 16'h7E7E, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_le_lo_act", {31'd0, a2.le_lo_act}, 32'd0);
    check("rst_le_hi_act", {31'd0, a2.le_hi_act}, 32'd0);
    check("rst_WEb_raw",   {31'd0, a2.WEb_raw}, 32'd1);
    check("rst_oe_act",    {31'd0, a2.oe_act}, 32'd0);
    check("rst_bus_in",    {24'd0, a2.bus_in}, 32'd0);
    check("rst_addr",      {16'd0, a2.addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      a2.bus_pins = vecs[v].data;
      if (vecs[v].lo)  a2.le_lo_pin = 1'b1;
      if (vecs[v].hi)  a2.le_hi_pin = 1'b1;
      if (vecs[v].web) a2.web_pin = 1'b0;
      if (vecs[v].oeb) a2.oeb_pin = 1'b0;
      web_low = 0; oe_high = 0; web_first = 0; oe_first = 0;
      total_e = vecs[v].width + vecs[v].hold + 12;
      for (int unsigned e = 1; e <= total_e; e++) begin
        @(negedge clk);
        if (a2.WEb_raw === 1'b0) begin
          if (web_low == 0) web_first = e - 1;
          web_low++;
        end
        if (a2.oe_act === 1'b1) begin
          if (oe_high == 0) oe_first = e - 1;
          oe_high++;
        end
        @(posedge clk); #1;
        if (e == vecs[v].width) begin
          a2.le_lo_pin = 1'b0; a2.le_hi_pin = 1'b0; a2.web_pin = 1'b1; a2.oeb_pin = 1'b1;
          if (vecs[v].exp_lo || vecs[v].exp_hi)
            sb.push_back('{cyc + 3 + FL2, vecs[v].exp_lo, vecs[v].exp_hi});
        end
        if (e == vecs[v].width + vecs[v].hold) a2.bus_pins = 8'hFF;
      end
      @(negedge clk);
      check({vecs[v].name, "_bus_in"},  {24'd0, a2.bus_in}, {24'd0, vecs[v].exp_bus});
      check({vecs[v].name, "_addr"},    {16'd0, a2.addr}, {16'd0, vecs[v].exp_addr});
      check({vecs[v].name, "_web_low"}, web_low, vecs[v].exp_web_low);
      check({vecs[v].name, "_oe_high"}, oe_high, vecs[v].exp_oe_high);
      if (vecs[v].exp_web_low > 0) check({vecs[v].name, "_web_lat"}, web_first, 2 + FL2);
      if (vecs[v].exp_oe_high > 0) check({vecs[v].name, "_oe_lat"}, oe_first, 2 + FL2);
    end

    // Reset while le_hi is held active, then release with the pin still high.
    @(posedge clk); #1;
    a2.le_hi_pin = 1'b1;
    a2.bus_pins  = 8'h3C;
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_bus_in", {24'd0, a2.bus_in}, 32'h3C);
    rst_n = 1'b0;
    #1;
    check("mid_rst_le_lo_act", {31'd0, a2.le_lo_act}, 32'd0);
    check("mid_rst_le_hi_act", {31'd0, a2.le_hi_act}, 32'd0);
    check("mid_rst_WEb_raw",   {31'd0, a2.WEb_raw}, 32'd1);
    check("mid_rst_oe_act",    {31'd0, a2.oe_act}, 32'd0);
    check("mid_rst_bus_in",    {24'd0, a2.bus_in}, 32'd0);
    check("mid_rst_addr",      {16'd0, a2.addr}, 32'd0);
    check("mid_rst_filt_hi",   {31'd0, dut2.u_le_hi.filt}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    first = 99;
    for (int unsigned e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (dut2.u_le_hi.filt === 1'b1 && first == 99) first = e - 1;
      @(posedge clk); #1;
    end
    check("post_rst_filt_lat", first, 2 + FL2);
    a2.le_hi_pin = 1'b0;
    sb.push_back('{cyc + 3 + FL2, 1'b0, 1'b1});
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("post_rst_addr",   {16'd0, a2.addr}, 32'h3C00);
    check("post_rst_bus_in", {24'd0, a2.bus_in}, 32'h3C);

    // FILTER_LEN sweep: 1-clock pulse accepted at FL=1, 14-clock pulse rejected at FL=15.
    @(posedge clk); #1;
    a1.web_pin = 1'b0; a15.web_pin = 1'b0;
    l1 = 0; f1 = 0; l15 = 0; f15 = 0;
    for (int unsigned e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (a1.WEb_raw === 1'b0)  begin if (l1 == 0)  f1 = e - 1;  l1++;  end
      if (a15.WEb_raw === 1'b0) begin if (l15 == 0) f15 = e - 1; l15++; end
      @(posedge clk); #1;
      if (e == 1)  a1.web_pin = 1'b1;
      if (e == 14) a15.web_pin = 1'b1;
    end
    check("fl1_lat",       f1, 3);
    check("fl1_width",     l1, 1);
    check("fl15_reject",   l15, 0);

    @(posedge clk); #1;
    a1.web_pin = 1'b0; a15.web_pin = 1'b0;
    l1 = 0; f1 = 0; l15 = 0; f15 = 0;
    for (int unsigned e = 1; e <= 45; e++) begin
      @(negedge clk);
      if (a1.WEb_raw === 1'b0)  begin if (l1 == 0)  f1 = e - 1;  l1++;  end
      if (a15.WEb_raw === 1'b0) begin if (l15 == 0) f15 = e - 1; l15++; end
      @(posedge clk); #1;
      if (e == 2)  a1.web_pin = 1'b1;
      if (e == 15) a15.web_pin = 1'b1;
    end
    check("fl1_lat2",    f1, 3);
    check("fl1_width2",  l1, 2);
    check("fl15_lat",    f15, 17);
    check("fl15_width",  l15, 15);

    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
